// File: rtl/regfile_debug_access.sv
// regfile_debug_access: debug initiator turning READ/WRITE/DUMP commands into register-file port accesses
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data command channel;
// rsp_valid/rsp_ready/rsp_addr/rsp_data/rsp_last response channel; rf_* register-file port; busy when not IDLE.
module regfile_debug_access #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_should_write,
  output logic [31:0]       rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] cur_addr, wr_addr;
  logic [DATA_W-1:0] cur_data;
  logic dump_mode, accept, rsp_done, dump_next;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_ready && cmd_valid;
  assign rsp_done = state == RSP && rsp_ready;
  assign dump_next = dump_mode && !rsp_last;
  assign rf_read_addr = cur_addr;
  // x0 is hardwired zero, so its write strobe is suppressed
  assign rf_should_write = state == WR && cur_addr != '0;
  // wr_addr/cur_data only change on WRITE acceptance, so the write port holds its last values
  assign rf_write_addr = 32'(wr_addr);
  assign rf_write_data = cur_data;
  // READ (01) and DUMP (11) share the RD path; NOP (00) is dropped
  always_comb begin
    state_n = state;
    if (accept) state_n = cmd_op == OP_WRITE ? WR : cmd_op[0] ? RD : IDLE;
    else if (state == RD || state == WR) state_n = RSP;
    else if (rsp_done) state_n = dump_next ? RD : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      wr_addr <= '0;
      cur_data <= '0;
      dump_mode <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && cmd_op != 2'b00) begin
        cur_addr <= cmd_op == OP_DUMP ? '0 : cmd_addr;
        dump_mode <= cmd_op == OP_DUMP;
      end
      if (accept && cmd_op == OP_WRITE) begin
        cur_data <= cmd_data;
        wr_addr <= cmd_addr;
      end
      if (state == RD || state == WR) begin
        rsp_valid <= 1'b1;
        rsp_addr <= cur_addr;
        rsp_data <= state == WR ? (cur_addr == '0 ? '0 : cur_data) : rf_read_data;
        rsp_last <= state == WR || !dump_mode || cur_addr == LAST_ADDR;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        if (dump_next) cur_addr <= cur_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_debug_access.sv
// tb_regfile_debug_access: randomized bench for regfile_debug_access against an architectural response model
module tb_regfile_debug_access;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 1;
  logic [1:0] cmd_op = 0;
  logic [AW-1:0] cmd_addr = 0;
  logic [DW-1:0] cmd_data = 0;
  logic cmd_ready, rsp_valid, rsp_last, rf_should_write, busy;
  logic [AW-1:0] rsp_addr, rf_read_addr;
  logic [DW-1:0] rsp_data, rf_read_data, rf_write_data;
  logic [31:0] rf_write_addr;
  always #5 clk = ~clk;
  regfile_debug_access #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_last(rsp_last), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_should_write(rf_should_write), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .busy(busy)
  );
  // register file responder: combinational read, commit on falling edge
  logic [DW-1:0] rf [NR];
  bit rf_init = 0;
  assign rf_read_data = rf[rf_read_addr];
  always @(negedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < NR; i++) rf[i] = '0;
      rf_init = 1;
    end else if (rf_should_write) rf[rf_write_addr[AW-1:0]] = rf_write_data;
  end
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic l;} rsp_t;
  rsp_t exp_q[$];
  rsp_t last_hs;
  bit [DW-1:0] ref_regs [NR];
  bit active = 0, wr_exp = 0;
  logic [AW-1:0] wr_exp_a = 0;
  logic [DW-1:0] wr_exp_d = 0;
  int cyc = 0, acc_cyc = -100, n_cmp = 0, n_fail = 0, n_hs = 0, rdy_mode = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // model: every accepted command expands into its full list of expected responses
  always @(posedge clk) begin
    cyc++;
    wr_exp = 0;
    if (reset) begin
      exp_q.delete();
      active = 0;
      acc_cyc = -100;
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_hs++;
        last_hs = '{a: rsp_addr, d: rsp_data, l: rsp_last};
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_q.size() == 0) active = 0;
      end
      if (cmd_valid && cmd_ready) begin
        chk("accept_while_busy", active, 0);
        case (cmd_op)
          2'b01: begin
            exp_q.push_back('{a: cmd_addr, d: ref_regs[cmd_addr], l: 1'b1});
            acc_cyc = cyc;
            active = 1;
          end
          2'b10: begin
            if (cmd_addr != 0) ref_regs[cmd_addr] = cmd_data;
            exp_q.push_back('{a: cmd_addr, d: (cmd_addr == 0) ? '0 : cmd_data, l: 1'b1});
            wr_exp = cmd_addr != 0;
            wr_exp_a = cmd_addr;
            wr_exp_d = cmd_data;
            acc_cyc = cyc;
            active = 1;
          end
          2'b11: begin
            for (int i = 0; i < NR; i++) exp_q.push_back('{a: AW'(i), d: ref_regs[i], l: i == NR - 1});
            active = 1;
          end
          default: ;
        endcase
      end
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready", cmd_ready, !active);
      chk("busy", busy, active);
      if (cyc == acc_cyc) chk("latency_early", rsp_valid, 0);
      if (cyc == acc_cyc + 1) chk("latency_rise", rsp_valid, 1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          chk("rsp_addr", rsp_addr, exp_q[0].a);
          chk("rsp_data", rsp_data, exp_q[0].d);
          chk("rsp_last", rsp_last, exp_q[0].l);
        end
      end
      chk("rf_should_write", rf_should_write, wr_exp);
      if (wr_exp) begin
        chk("rf_write_addr", rf_write_addr, 32'(wr_exp_a));
        chk("rf_write_data", rf_write_data, wr_exp_d);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) :
                rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  task automatic send(input logic [1:0] op, input int a, input logic [DW-1:0] d);
    int g;
    g = 0;
    cmd_valid = 1;
    cmd_op = op;
    cmd_addr = AW'(a);
    cmd_data = d;
    do begin
      @(posedge clk);
      g++;
    end while (!cmd_ready && g < 2000);
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: op %0d not accepted after %0d cycles", op, g);
    end
    #1;
    cmd_valid = 0;
    cmd_op = 0;
  endtask
  task automatic wait_idle();
    int g;
    g = 0;
    while ((active || exp_q.size() != 0) && g < 3000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles", g);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int h0, g;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rf_write_addr", rf_write_addr, 0);
    chk("rst_rf_write_data", rf_write_data, 0);
    send(2'b10, 5, 32'hDEADBEEF);
    wait_idle();
    chk("w5_ack", last_hs.d, 32'hDEADBEEF);
    send(2'b01, 5, 0);
    wait_idle();
    chk("r5_addr", last_hs.a, 5);
    chk("r5_data", last_hs.d, 32'hDEADBEEF);
    chk("r5_last", last_hs.l, 1);
    chk("model_x5", ref_regs[5], 32'hDEADBEEF);
    send(2'b10, 0, 32'h12345678);
    wait_idle();
    chk("w0_ack", last_hs.d, 0);
    send(2'b01, 0, 0);
    wait_idle();
    chk("r0_data", last_hs.d, 0);
    for (int i = 1; i < NR; i++) send(2'b10, i, 32'(i) * 32'h11);
    wait_idle();
    h0 = n_hs;
    send(2'b11, 0, 0);
    wait_idle();
    chk("dump_count", n_hs - h0, NR);
    chk("dump_last_addr", last_hs.a, 31);
    chk("dump_last_data", last_hs.d, 32'h20F);
    @(negedge clk);
    chk("dump_done_ready", cmd_ready, 1);
    rdy_mode = 1;
    h0 = n_hs;
    send(2'b11, 0, 0);
    wait_idle();
    chk("stall_dump_count", n_hs - h0, NR);
    h0 = n_hs;
    send(2'b11, 0, 0);
    g = 0;
    while (n_hs - h0 < 9 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    rdy_mode = 3;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 100);
    chk("stall10_valid", rsp_valid, 1);
    chk("stall10_addr", rsp_addr, 9);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    rdy_mode = 0;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_more", n_hs - h0, 9);
    send(2'b01, 3, 0);
    wait_idle();
    chk("post_abort_r3", last_hs.d, 32'h33);
    h0 = n_hs;
    cmd_valid = 1;
    cmd_op = 2'b00;
    repeat (5) @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("nop_no_rsp", n_hs - h0, 0);
    rdy_mode = 3;
    send(2'b11, 0, 0);
    fork
      send(2'b01, 7, 0);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("ready_while_busy", cmd_ready, 0);
        end
        rdy_mode = 0;
      end
    join
    wait_idle();
    chk("held_read_addr", last_hs.a, 7);
    chk("held_read_data", last_hs.d, 32'h77);
    rdy_mode = 2;
    repeat (60) begin
      int r;
      r = $urandom_range(0, 9);
      send(r < 1 ? 2'b00 : r < 5 ? 2'b01 : r < 9 ? 2'b10 : 2'b11, $urandom_range(0, NR - 1), $urandom);
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
